// File: rtl/cmp_seq_pkg.sv
// Shared types for the bit-serial comparator: FSM state encoding and {lt,eq,gt} result codes.
package cmp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_EQ   = 3'b010;
  localparam logic [2:0] RES_GT   = 3'b001;
  localparam logic [2:0] RES_NONE = 3'b000;

  // Map the single-bit cell outputs onto a result code; only called once the bits differ.
  function automatic logic [2:0] res_from_cell(input logic cell_g);
    return cell_g ? RES_GT : RES_LT;
  endfunction

endpackage

// File: rtl/bit_cmp_cell.sv
// One-bit magnitude compare cell, purely combinational; exactly one of l/e/g is high.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic l,
  output logic e,
  output logic g
);

  assign g = a & ~b;
  assign l = ~a & b;
  assign e = ~(a ^ b);

endmodule

// File: rtl/comp_serial_nbit.sv
// Bit-serial WIDTH-bit magnitude comparator, MSB first; done in cycle WIDTH+1 after accept.
// Starts are ignored while busy. Macro EARLY_EXIT_EN ends the compare on the first mismatching bit.
module comp_serial_nbit
  import cmp_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             decided_q, decided_d;
  logic [2:0]       res_q, res_d;

  logic cell_l, cell_e, cell_g;
  logic accept;

  bit_cmp_cell u_cell (
    .a (a_sh_q[WIDTH-1]),
    .b (b_sh_q[WIDTH-1]),
    .l (cell_l),
    .e (cell_e),
    .g (cell_g)
  );

  // IDLE and DONE both count as not busy, which is what makes back-to-back starts work.
  assign accept = start && (state_q != SHIFT);

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    cnt_d     = cnt_q;
    decided_d = decided_q;
    res_d     = res_q;

    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        cnt_d  = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
        // cell_l is implied by !cell_e && !cell_g; kept in the condition for readability.
        if (!decided_q && (cell_l || cell_g)) begin
          res_d     = res_from_cell(cell_g);
          decided_d = 1'b1;
`ifdef EARLY_EXIT_EN
          state_d   = DONE;
`endif
        end
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!decided_q && cell_e) begin
            res_d = RES_EQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = SHIFT;
      a_sh_d    = a;
      b_sh_d    = b;
      cnt_d     = CW'(WIDTH - 1);
      decided_d = 1'b0;
      res_d     = RES_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      cnt_q     <= '0;
      decided_q <= 1'b0;
      res_q     <= RES_NONE;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      cnt_q     <= cnt_d;
      decided_q <= decided_d;
      res_q     <= res_d;
    end
  end

  assign busy         = (state_q == SHIFT);
  assign done         = (state_q == DONE);
  assign {lt, eq, gt} = res_q;

endmodule
